// File: rtl/xgmii_pattern_checker.sv
// xgmii_pattern_checker
//
// Fixed-pattern checker for the XGMII receive side of eth_phy_10g. It locks
// onto the repeating six-word data sequence sent by the fixed-pattern
// data-block test and then counts errored words and errored bits.
//
// The pattern table (index 0..5) is FFFF.., 0000.., 5555.., AAAA.., FEFE..,
// 0707... Every entry expects xgmii_rxc == 0.
//
// Ports
//   rx_clk            receive clock, all logic on the rising edge
//   rx_rst_n          asynchronous active-low reset
//   enable            checker enable; low forces SEARCH and ignores input
//   rx_block_lock     PCS block lock; low behaves like enable low
//   clear             synchronous clear of both error counters
//   xgmii_rxd         received data word
//   xgmii_rxc         received control flags
//   pattern_lock      sequence locked
//   error_pulse       one-cycle pulse per errored word while locked
//   word_error_count  errored words while locked, saturating
//   bit_error_count   errored bits while locked, saturating
//   exp_index         expected pattern index for the next word, 0..5

module xgmii_pattern_checker #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_ERRORS = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst_n,
    input  logic                   enable,
    input  logic                   rx_block_lock,
    input  logic                   clear,
    input  logic [DATA_WIDTH-1:0]  xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0]  xgmii_rxc,
    output logic                   pattern_lock,
    output logic                   error_pulse,
    output logic [COUNT_WIDTH-1:0] word_error_count,
    output logic [COUNT_WIDTH-1:0] bit_error_count,
    output logic [2:0]             exp_index
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRORS + 1);
    // Worst case per word: every data bit wrong plus one for bad control.
    localparam int POP_W  = $clog2(DATA_WIDTH + 2);
    // Bit counter sum is formed one bit wider than either operand so the
    // clamp can see an overflow instead of a wrapped value.
    localparam int SUM_W  = ((COUNT_WIDTH > POP_W) ? COUNT_WIDTH : POP_W) + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             expIdx_q, expIdx_d;
    logic [GOOD_W-1:0]      goodCnt_q, goodCnt_d;
    logic [BAD_W-1:0]       badRun_q, badRun_d;
    logic                   lock_q, lock_d;
    logic                   pulse_q, pulse_d;
    logic [COUNT_WIDTH-1:0] wordCnt_q, wordCnt_d;
    logic [COUNT_WIDTH-1:0] bitCnt_q, bitCnt_d;

    logic                   qual;
    logic                   rxcZero;
    logic [DATA_WIDTH-1:0]  expWord;
    logic [DATA_WIDTH-1:0]  diffWord;
    logic                   expMatch;
    logic                   anyMatch;
    logic [2:0]             hitIdx;
    logic [POP_W-1:0]       popCnt;
    logic [SUM_W-1:0]       bitSum;

    function automatic logic [DATA_WIDTH-1:0] patternWord(input logic [2:0] idx);
        case (idx)
            3'd0:    patternWord = {(DATA_WIDTH / 8){8'hFF}};
            3'd1:    patternWord = {(DATA_WIDTH / 8){8'h00}};
            3'd2:    patternWord = {(DATA_WIDTH / 8){8'h55}};
            3'd3:    patternWord = {(DATA_WIDTH / 8){8'hAA}};
            3'd4:    patternWord = {(DATA_WIDTH / 8){8'hFE}};
            3'd5:    patternWord = {(DATA_WIDTH / 8){8'h07}};
            default: patternWord = '0;
        endcase
    endfunction

    function automatic logic [2:0] nextIdx(input logic [2:0] idx);
        nextIdx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    assign qual     = enable & rx_block_lock;
    assign rxcZero  = (xgmii_rxc == '0);
    assign expWord  = patternWord(expIdx_q);
    assign diffWord = xgmii_rxd ^ expWord;
    assign expMatch = rxcZero && (diffWord == '0);

    // Table entries are distinct, so at most one can hit; the first wins.
    always_comb begin
        anyMatch = 1'b0;
        hitIdx   = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (!anyMatch && rxcZero && (xgmii_rxd == patternWord(3'(k)))) begin
                anyMatch = 1'b1;
                hitIdx   = 3'(k);
            end
        end
    end

    // Bit error weight of the word: differing data bits plus one for any
    // non-zero control flag.
    always_comb begin
        popCnt = POP_W'(!rxcZero);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            popCnt = popCnt + POP_W'(diffWord[i]);
        end
    end

    assign bitSum = SUM_W'(bitCnt_q) + SUM_W'(popCnt);

    always_comb begin
        state_d   = state_q;
        expIdx_d  = expIdx_q;
        goodCnt_d = goodCnt_q;
        badRun_d  = badRun_q;
        lock_d    = lock_q;
        pulse_d   = 1'b0;
        wordCnt_d = wordCnt_q;
        bitCnt_d  = bitCnt_q;

        if (!qual) begin
            state_d   = SEARCH;
            lock_d    = 1'b0;
            goodCnt_d = '0;
            badRun_d  = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    lock_d = 1'b0;
                    if (anyMatch) begin
                        expIdx_d  = nextIdx(hitIdx);
                        goodCnt_d = GOOD_W'(1);
                        state_d   = VERIFY;
                    end
                end
                VERIFY: begin
                    if (expMatch) begin
                        expIdx_d = nextIdx(expIdx_q);
                        if (goodCnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d   = LOCKED;
                            lock_d    = 1'b1;
                            goodCnt_d = '0;
                            badRun_d  = '0;
                        end else begin
                            goodCnt_d = goodCnt_q + GOOD_W'(1);
                        end
                    end else begin
                        // The failing word is dropped, not re-searched.
                        state_d   = SEARCH;
                        goodCnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running expectation once locked, so a single bad
                    // word does not shift the alignment.
                    expIdx_d = nextIdx(expIdx_q);
                    if (expMatch) begin
                        badRun_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        if (wordCnt_q != CNT_MAX) begin
                            wordCnt_d = wordCnt_q + COUNT_WIDTH'(1);
                        end
                        if (bitSum > SUM_W'(CNT_MAX)) begin
                            bitCnt_d = CNT_MAX;
                        end else begin
                            bitCnt_d = bitSum[COUNT_WIDTH-1:0];
                        end
                        if (badRun_q == BAD_W'(UNLOCK_ERRORS - 1)) begin
                            state_d  = SEARCH;
                            lock_d   = 1'b0;
                            badRun_d = '0;
                        end else begin
                            badRun_d = badRun_q + BAD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    lock_d  = 1'b0;
                end
            endcase
        end

        // Clear overrides any increment made on the same edge.
        if (clear) begin
            wordCnt_d = '0;
            bitCnt_d  = '0;
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q   <= SEARCH;
            expIdx_q  <= 3'd0;
            goodCnt_q <= '0;
            badRun_q  <= '0;
            lock_q    <= 1'b0;
            pulse_q   <= 1'b0;
            wordCnt_q <= '0;
            bitCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            expIdx_q  <= expIdx_d;
            goodCnt_q <= goodCnt_d;
            badRun_q  <= badRun_d;
            lock_q    <= lock_d;
            pulse_q   <= pulse_d;
            wordCnt_q <= wordCnt_d;
            bitCnt_q  <= bitCnt_d;
        end
    end

    assign pattern_lock     = lock_q;
    assign error_pulse      = pulse_q;
    assign word_error_count = wordCnt_q;
    assign bit_error_count  = bitCnt_q;
    assign exp_index        = expIdx_q;

endmodule

// File: tb/tb_xgmii_pattern_checker.sv
// tb_xgmii_pattern_checker
//
// Bench for xgmii_pattern_checker built with COUNT_WIDTH = 4 so counter
// saturation is reachable in a short run. Directed scenarios walk through
// reset, clean lock, corruption, loss of lock, qualifier drop, saturation,
// clear and a mid-run reset; a randomized stream follows. A behavioural
// model tracks the expected outputs for every sample.

module tb_xgmii_pattern_checker;

    localparam int CW     = 4;
    localparam int LOCKN  = 4;
    localparam int UNLOCK = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk       = 1'b0;
    logic          rstN      = 1'b0;
    logic          enable    = 1'b0;
    logic          blockLock = 1'b0;
    logic          clr       = 1'b0;
    logic [63:0]   rxd       = '0;
    logic [7:0]    rxc       = '0;
    logic          patternLock;
    logic          errorPulse;
    logic [CW-1:0] wordErrors;
    logic [CW-1:0] bitErrors;
    logic [2:0]    expIndex;

    int checks = 0;
    int errors = 0;

    // Model view: mode 0 = hunting, 1 = confirming, 2 = locked.
    int mMode, mIdx, mGood, mBad, mWords, mBits, mLock, mPulse;
    int txIdx;

    xgmii_pattern_checker #(
        .DATA_WIDTH   (64),
        .CTRL_WIDTH   (8),
        .LOCK_COUNT   (LOCKN),
        .UNLOCK_ERRORS(UNLOCK),
        .COUNT_WIDTH  (CW)
    ) dut (
        .rx_clk          (clk),
        .rx_rst_n        (rstN),
        .enable          (enable),
        .rx_block_lock   (blockLock),
        .clear           (clr),
        .xgmii_rxd       (rxd),
        .xgmii_rxc       (rxc),
        .pattern_lock    (patternLock),
        .error_pulse     (errorPulse),
        .word_error_count(wordErrors),
        .bit_error_count (bitErrors),
        .exp_index       (expIndex)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] patWord(input int i);
        case (i)
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h0000_0000_0000_0000;
            2:       return 64'h5555_5555_5555_5555;
            3:       return 64'hAAAA_AAAA_AAAA_AAAA;
            4:       return 64'hFEFE_FEFE_FEFE_FEFE;
            default: return 64'h0707_0707_0707_0707;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mIdx = 0; mGood = 0; mBad = 0;
        mWords = 0; mBits = 0; mLock = 0; mPulse = 0;
    endtask

    // Advance the model by one rising edge with the given sample.
    task automatic modelStep(input logic [63:0] d, input logic [7:0] c, input bit q, input bit cl);
        logic [63:0] want;
        mPulse = 0;
        if (!q) begin
            mMode = 0; mLock = 0; mGood = 0; mBad = 0;
        end else if (mMode == 0) begin
            for (int k = 0; k < 6; k++) begin
                if (c == 8'h00 && d == patWord(k)) begin
                    mIdx = (k + 1) % 6; mGood = 1; mMode = 1;
                    break;
                end
            end
        end else if (mMode == 1) begin
            if (c == 8'h00 && d == patWord(mIdx)) begin
                mGood++;
                mIdx = (mIdx + 1) % 6;
                if (mGood == LOCKN) begin
                    mMode = 2; mLock = 1; mBad = 0;
                end
            end else begin
                mMode = 0; mGood = 0;
            end
        end else begin
            want = patWord(mIdx);
            mIdx = (mIdx + 1) % 6;
            if (c == 8'h00 && d == want) begin
                mBad = 0;
            end else begin
                mPulse = 1;
                mWords = (mWords + 1 > CMAX) ? CMAX : mWords + 1;
                mBits  = mBits + $countones(d ^ want) + ((c != 8'h00) ? 1 : 0);
                if (mBits > CMAX) mBits = CMAX;
                mBad++;
                if (mBad == UNLOCK) begin
                    mMode = 0; mLock = 0; mBad = 0;
                end
            end
        end
        if (cl) begin
            mWords = 0; mBits = 0;
        end
    endtask

    task automatic compareModel();
        checkOutput("lock", 64'(patternLock), 64'(mLock));
        checkOutput("pulse", 64'(errorPulse), 64'(mPulse));
        checkOutput("wordCnt", 64'(wordErrors), 64'(mWords));
        checkOutput("bitCnt", 64'(bitErrors), 64'(mBits));
        if (mMode != 0) checkOutput("expIdx", 64'(expIndex), 64'(mIdx));
    endtask

    // Drive one sample, let one edge pass, then compare #1 after the edge.
    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] c,
                                 input logic en, input logic bl, input logic cl);
        rxd = d; rxc = c; enable = en; blockLock = bl; clr = cl;
        @(posedge clk);
        modelStep(d, c, en & bl, cl);
        #1;
        compareModel();
    endtask

    task automatic sendSeq(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(patWord(txIdx), 8'h00, 1'b1, 1'b1, 1'b0);
            txIdx = (txIdx + 1) % 6;
        end
    endtask

    task automatic alignTo(input int idx);
        for (int i = 0; i < 6 && txIdx != idx; i++) sendSeq(1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_lock"}, 64'(patternLock), 64'd0);
        checkOutput({tag, "_pulse"}, 64'(errorPulse), 64'd0);
        checkOutput({tag, "_word"}, 64'(wordErrors), 64'd0);
        checkOutput({tag, "_bit"}, 64'(bitErrors), 64'd0);
        checkOutput({tag, "_idx"}, 64'(expIndex), 64'd0);
    endtask

    initial begin
        int r;
        logic [63:0] d;
        logic [7:0]  c;
        logic        en, bl, cl;
        int          savedWords, savedBits;

        modelReset();
        txIdx = 0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            rxd = patWord(i); rxc = 8'(i); enable = i[0]; blockLock = 1'b1; clr = i[1];
            @(posedge clk);
            #1;
            checkAllZero("rst");
        end
        rstN = 1'b1;

        // Clean lock starting at index 2.
        txIdx = 2;
        sendSeq(3);
        checkOutput("preLock", 64'(patternLock), 64'd0);
        sendSeq(1);
        checkOutput("lockRise", 64'(patternLock), 64'd1);
        sendSeq(96);
        checkOutput("cleanWords", 64'(wordErrors), 64'd0);
        checkOutput("cleanBits", 64'(bitErrors), 64'd0);

        // Single corruption on the 5555 word.
        alignTo(2);
        applyStimulus(64'h5555_5555_5555_5550, 8'h00, 1'b1, 1'b1, 1'b0);
        txIdx = 3;
        checkOutput("corrPulse", 64'(errorPulse), 64'd1);
        checkOutput("corrWords", 64'(wordErrors), 64'd1);
        checkOutput("corrBits", 64'(bitErrors), 64'd2);
        checkOutput("corrLock", 64'(patternLock), 64'd1);
        sendSeq(1);
        checkOutput("corrNextPulse", 64'(errorPulse), 64'd0);
        checkOutput("corrNextIdx", 64'(expIndex), 64'd4);
        checkOutput("corrNextWords", 64'(wordErrors), 64'd1);

        // Loss of lock after four bad words.
        applyStimulus(patWord(txIdx), 8'h00, 1'b1, 1'b1, 1'b1);
        txIdx = (txIdx + 1) % 6;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1, 1'b1, 1'b0);
            txIdx = (txIdx + 1) % 6;
            if (i == 2) checkOutput("lossHeld", 64'(patternLock), 64'd1);
        end
        checkOutput("lossWords", 64'(wordErrors), 64'd4);
        checkOutput("lossLock", 64'(patternLock), 64'd0);
        sendSeq(3);
        checkOutput("relockPre", 64'(patternLock), 64'd0);
        sendSeq(1);
        checkOutput("relock", 64'(patternLock), 64'd1);

        // Qualifier drop for three cycles.
        savedWords = int'(wordErrors);
        savedBits  = int'(bitErrors);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(64'hDEAD_BEEF_0000_0001, 8'h01, 1'b1, 1'b0, 1'b0);
            txIdx = (txIdx + 1) % 6;
            checkOutput("dropLock", 64'(patternLock), 64'd0);
            checkOutput("dropWords", 64'(wordErrors), 64'(savedWords));
            checkOutput("dropBits", 64'(bitErrors), 64'(savedBits));
        end
        sendSeq(3);
        checkOutput("dropRelockPre", 64'(patternLock), 64'd0);
        sendSeq(1);
        checkOutput("dropRelock", 64'(patternLock), 64'd1);

        // Saturation: all-ones in place of the 0000 word, twenty times.
        applyStimulus(patWord(txIdx), 8'h00, 1'b1, 1'b1, 1'b1);
        txIdx = (txIdx + 1) % 6;
        for (int i = 0; i < 120; i++) begin
            d = (txIdx == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : patWord(txIdx);
            applyStimulus(d, 8'h00, 1'b1, 1'b1, 1'b0);
            txIdx = (txIdx + 1) % 6;
        end
        checkOutput("satWords", 64'(wordErrors), 64'd15);
        checkOutput("satBits", 64'(bitErrors), 64'd15);
        checkOutput("satLock", 64'(patternLock), 64'd1);
        alignTo(1);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 1'b1, 1'b1);
        txIdx = 2;
        checkOutput("clrPulse", 64'(errorPulse), 64'd1);
        checkOutput("clrWords", 64'(wordErrors), 64'd0);
        checkOutput("clrBits", 64'(bitErrors), 64'd0);

        // Asynchronous reset between edges.
        sendSeq(2);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkAllZero("asyncRst");
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Randomized stream with corruption, qualifier drops, clears, slips.
        for (int n = 0; n < 1500; n++) begin
            d = patWord(txIdx); c = 8'h00; en = 1'b1; bl = 1'b1;
            cl = ($urandom_range(0, 99) < 2);
            r  = $urandom_range(0, 99);
            if ((n % 200) >= 190 && (n % 200) < 195) begin
                d = {$urandom, $urandom};
            end else if (r < 80) begin
                d = patWord(txIdx);
            end else if (r < 88) begin
                d = patWord(txIdx) ^ (64'd1 << $urandom_range(0, 63));
            end else if (r < 92) begin
                c = 8'($urandom_range(1, 255));
            end else if (r < 95) begin
                d = {$urandom, $urandom};
            end else if (r < 98) begin
                en = $urandom_range(0, 1) == 1;
                bl = en ? 1'b0 : ($urandom_range(0, 1) == 1);
            end else begin
                txIdx = $urandom_range(0, 5);
                d = patWord(txIdx);
            end
            applyStimulus(d, c, en, bl, cl);
            txIdx = (txIdx + 1) % 6;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
